texture_ram_loader: RTL
=======================

# texture_ram_loader

Writable 64x64 texture store at the far end of the sprite pixel-fetch interface. Answers a draw stage's 12-bit `address` with a registered 12-bit `rgb` word, one-cycle latency, like the texture ROMs it replaces. Also accepts a byte stream over a valid/ready handshake, packs byte pairs into 12-bit pixels and writes them sequentially from address 0. Textures can therefore be reloaded at run time instead of baked into ROM.

## Interface
- `ADDR_W`, 12: read/write address width; depth is 2^ADDR_W (4096 = {y[5:0], x[5:0]}).
- `KEY_RGB`, 12'h0FF: transparency key written by the clear sweep.

Ports:
- `pclk`  in  1  pixel clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDR_W  read address from the draw stage.
- `rgb`  out  12  registered read data, {R,G,B} 4 bits each.
- `load_start`  in  1  single-cycle request to begin a full-texture load.
- `byte_data`  in  8  load stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  clear sweep or load in progress.
- `done`  out  1  one-cycle pulse after the last pixel of a load is written.

## Operation
- FSM states: CLEAR (present only with macro), IDLE, LOAD_HI, LOAD_LO, DONE. Reset state is CLEAR with the macro, IDLE without it.
- A byte is accepted on any rising edge where `byte_valid && byte_ready`. `byte_ready` is 1 only in LOAD_HI and LOAD_LO, and is a pure decode of the state.
- IDLE: `load_start`=1 clears `wr_addr` to 0 and moves to LOAD_HI. In every other state `load_start` is ignored.
- LOAD_HI: on accept, latch `byte_data[3:0]` as R (upper nibble discarded) and move to LOAD_LO.
- LOAD_LO: on accept, write {R, `byte_data`} to `mem[wr_addr]`.
  - If `wr_addr` is 2^ADDR_W-1, move to DONE.
  - Otherwise increment `wr_addr` and return to LOAD_HI.
- Without accept, LOAD_HI and LOAD_LO hold. Gaps in `byte_valid` of any length are legal.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- CLEAR: write `KEY_RGB` to `mem[wr_addr]` every cycle, `wr_addr` counting 0 to 2^ADDR_W-1. After writing the last address, go to IDLE.
- `busy` = 1 in CLEAR, LOAD_HI and LOAD_LO; 0 in IDLE and DONE.
- Read port is independent of the FSM: `rgb <= mem[address]` every cycle, in every state.
- Same-address read and write in one cycle is read-first: `rgb` returns the old word, and the new word is visible from the next read.
- `wr_addr` is ADDR_W bits and never wraps during a load, because terminal detection happens before the increment.

## Timing
- Read latency is 1: `address` sampled at edge k gives `rgb` valid after edge k, until edge k+1.
- Write latency: a pixel written at edge k is readable by an `address` sampled at edge k+1 or later.
- `done` goes high after the edge that accepts the final LO byte and drops one edge later.
- Reset values while `rst_n`=0:
  - `rgb`=0, `byte_ready`=0, `done`=0, `wr_addr`=0, R latch=0.
  - `busy`=1 with the macro, 0 without it.
- Memory contents are not reset.
- Reset mid-load abandons the load. Pixels already written keep their values unless a clear sweep overwrites them. A half-received pixel is discarded.
- Full load = 2·2^ADDR_W accepted bytes, minimum 8192 cycles at full throughput (one byte per cycle).

## Configuration
- `TEXTURE_RAM_CLEAR_EN` defined:
  - After reset release, a CLEAR sweep of 2^ADDR_W cycles fills memory with `KEY_RGB`.
  - During the sweep, `busy`=1 and `byte_ready`=0; the read port stays live.
- Undefined: no CLEAR state. The FSM resets to IDLE, `busy`=0 immediately, and memory is uninitialised until loaded.

## Test plan
- Macro on, release `rst_n`: `busy` stays 1 for exactly 4096 cycles then 0; afterwards `address`=12'h123 gives `rgb`=12'h0FF one cycle later.
- `load_start` pulse, then 8192 back-to-back bytes where pixel i is sent as {4'h0,i[11:8]}, i[7:0]:
  - `done` pulses exactly once, one cycle after the last accept.
  - `address`=12'hABC then reads `rgb`=12'hABC.
- Byte stream 8'hF5, 8'h67 with random 0–5 cycle `byte_valid` gaps: `mem[0]`=12'h567 (upper nibble dropped); `byte_ready` never high outside LOAD states.
- Hold `address`=5 while writing pixel 5 = 12'h3C4 over old 12'h111: `rgb` shows 12'h111 for the cycle after the write edge, then 12'h3C4.
- `load_start` asserted during LOAD_HI and during DONE: ignored, `wr_addr` sequence unchanged, exactly one `done`.
- Macro off, assert `rst_n`=0 after 100 accepted bytes:
  - Outputs go to their reset values immediately.
  - Pixels 0..49 retain their loaded values.
  - A new load rewrites from address 0.

Source files
------------

// File: rtl/texture_ram_loader.sv
// texture_ram_loader
//   Writable 2^ADDR_W x 12-bit texture store. It has a registered read port
//   (one-cycle latency, read-first) for the sprite draw stage. It also has a
//   byte-stream loader that packs {R nibble, GB byte} pairs into pixels and
//   writes them sequentially from address 0.
//
//   Optional feature macro: TEXTURE_RAM_CLEAR_EN
//     When defined, a sweep after reset fills the memory with KEY_RGB.
//
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   address     in   read address {y, x}
//   rgb         out  registered read data {R,G,B}
//   load_start  in   begins a full-texture load (honoured in IDLE only)
//   byte_data   in   load stream byte
//   byte_valid  in   byte_data valid
//   byte_ready  out  byte accepted this cycle when byte_valid is high
//   busy        out  clear sweep or load in progress
//   done        out  one-cycle pulse after the last pixel is written
module texture_ram_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [11:0] KEY_RGB = 12'h0FF
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [11:0]       rgb,
    input  logic              load_start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              busy,
    output logic              done
);

`ifdef TEXTURE_RAM_CLEAR_EN
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_DONE
    } state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_DONE
    } state_t;
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [11:0]       mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        red_q, red_d;
    logic [11:0]       rgb_q;

    logic              mem_we;
    logic [11:0]       mem_wdata;
    logic              last_addr;

    assign last_addr = (wr_addr_q == '1);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            wr_addr_q <= '0;
            red_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            red_q     <= red_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        red_d     = red_q;
        mem_we    = 1'b0;
        mem_wdata = {red_q, byte_data};

        unique case (state_q)
`ifdef TEXTURE_RAM_CLEAR_EN
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = KEY_RGB;
                if (last_addr) begin
                    wr_addr_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
`endif
            ST_IDLE: begin
                if (load_start) begin
                    wr_addr_d = '0;
                    state_d   = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (byte_valid) begin
                    red_d   = byte_data[3:0];
                    state_d = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                if (byte_valid) begin
                    mem_we = 1'b1;
                    // Terminal check precedes the increment so wr_addr never wraps.
                    if (last_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        state_d   = ST_LOAD_HI;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= mem_wdata;
        end
    end

    // Read-first: a same-cycle write is seen only by the following read.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= mem[address];
        end
    end

    assign rgb        = rgb_q;
    assign byte_ready = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
`ifdef TEXTURE_RAM_CLEAR_EN
    assign busy       = byte_ready || (state_q == ST_CLEAR);
`else
    assign busy       = byte_ready;
`endif
    assign done       = (state_q == ST_DONE);

endmodule
